// File: rtl/cdma_ctrl_if.sv
// Bus bundle for the CDMA transfer sequencer: config, read/write command
// channels and the data-buffer strobes. master = sequencer side.
interface cdma_ctrl_if #(
    parameter int LEN_W = 16
);
    logic             cfg_start;
    logic [31:0]      cfg_src_addr;
    logic [31:0]      cfg_dst_addr;
    logic [LEN_W-1:0] cfg_len;
    logic             cfg_busy;
    logic             cfg_done;

    logic             rd_req;
    logic [31:0]      rd_addr;
    logic [4:0]       rd_len;
    logic             rd_ack;
    logic             rd_dvalid;
    logic [31:0]      rd_data;

    logic             wr_req;
    logic [31:0]      wr_addr;
    logic [4:0]       wr_len;
    logic             wr_ack;
    logic             wr_dvalid;
    logic             wr_dready;
    logic [31:0]      wr_data;
    logic             wr_last;

    logic             buf_wr;
    logic [31:0]      buf_wdata;
    logic             buf_rd;
    logic [31:0]      buf_rdata;
    logic [5:0]       buf_buf_word;
    logic             buf_empty;

    modport master (
        input  cfg_start, cfg_src_addr, cfg_dst_addr, cfg_len,
        output cfg_busy, cfg_done,
        output rd_req, rd_addr, rd_len,
        input  rd_ack, rd_dvalid, rd_data,
        output wr_req, wr_addr, wr_len,
        input  wr_ack,
        output wr_dvalid,
        input  wr_dready,
        output wr_data, wr_last,
        output buf_wr, buf_wdata, buf_rd,
        input  buf_rdata, buf_buf_word, buf_empty
    );

    modport slave (
        output cfg_start, cfg_src_addr, cfg_dst_addr, cfg_len,
        input  cfg_busy, cfg_done,
        input  rd_req, rd_addr, rd_len,
        output rd_ack, rd_dvalid, rd_data,
        input  wr_req, wr_addr, wr_len,
        output wr_ack,
        input  wr_dvalid,
        output wr_dready,
        input  wr_data, wr_last,
        input  buf_wr, buf_wdata, buf_rd,
        output buf_rdata, buf_buf_word, buf_empty
    );
endinterface

// File: rtl/cdma_ctrl.sv
// CDMA transfer sequencer: splits a word-count descriptor into read bursts
// that fill the data buffer and write bursts that drain it, gated on occupancy.
module cdma_ctrl #(
    parameter int BURST_LEN = 8,
    parameter int BUF_DEPTH = 24,
    parameter int LEN_W     = 16
) (
    input  logic         clk,
    input  logic         rstn,
    cdma_ctrl_if.master  bus
);

    localparam logic [1:0] R_IDLE = 2'd0;
    localparam logic [1:0] R_REQ  = 2'd1;
    localparam logic [1:0] R_DATA = 2'd2;

    localparam logic [1:0] W_IDLE = 2'd0;
    localparam logic [1:0] W_REQ  = 2'd1;
    localparam logic [1:0] W_DATA = 2'd2;

    logic             r_busy;
    logic             r_done;

    logic [1:0]       r_rd_state;
    logic [31:0]      r_rd_addr;
    logic [LEN_W-1:0] r_rd_remain;
    logic [4:0]       r_rd_beat;

    logic [1:0]       r_wr_state;
    logic [31:0]      r_wr_addr;
    logic [LEN_W-1:0] r_wr_remain;
    logic [4:0]       r_wr_beat;

    logic             w_start;
    logic [4:0]       w_rd_burst;
    logic [4:0]       w_wr_burst;
    logic [6:0]       w_buf_free;
    logic             w_rd_go;
    logic             w_wr_go;
    logic             w_rd_last;
    logic             w_wr_last;
    logic             w_wr_accept;
    logic             w_wr_final;

    assign w_start = bus.cfg_start & ~r_busy;

    assign w_rd_burst = (r_rd_remain >= LEN_W'(BURST_LEN)) ? 5'(BURST_LEN) : r_rd_remain[4:0];
    assign w_wr_burst = (r_wr_remain >= LEN_W'(BURST_LEN)) ? 5'(BURST_LEN) : r_wr_remain[4:0];

    // Occupancy never exceeds BUF_DEPTH, so the free count cannot underflow.
    assign w_buf_free = 7'(BUF_DEPTH) - {1'b0, bus.buf_buf_word};

    assign w_rd_go = r_busy && (r_rd_remain != '0) && (w_buf_free >= {2'b00, w_rd_burst});
    assign w_wr_go = r_busy && (r_wr_remain != '0) && !bus.buf_empty
                     && (bus.buf_buf_word >= {1'b0, w_wr_burst});

    assign w_rd_last   = (r_rd_beat == w_rd_burst - 5'd1);
    assign w_wr_last   = (r_wr_beat == w_wr_burst - 5'd1);
    assign w_wr_accept = (r_wr_state == W_DATA) && bus.wr_dready;
    assign w_wr_final  = w_wr_accept && w_wr_last && (r_wr_remain == LEN_W'(w_wr_burst));

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_busy <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_start) begin
                r_busy <= |bus.cfg_len;
                r_done <= ~|bus.cfg_len;
            end else if (w_wr_final) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rd_state  <= R_IDLE;
            r_rd_addr   <= '0;
            r_rd_remain <= '0;
            r_rd_beat   <= '0;
        end else begin
            case (r_rd_state)
                R_IDLE: begin
                    if (w_start) begin
                        r_rd_addr   <= bus.cfg_src_addr & 32'hFFFF_FFFC;
                        r_rd_remain <= bus.cfg_len;
                    end else if (w_rd_go) begin
                        r_rd_state <= R_REQ;
                    end
                end
                R_REQ: begin
                    if (bus.rd_ack) begin
                        r_rd_state <= R_DATA;
                        r_rd_beat  <= '0;
                    end
                end
                R_DATA: begin
                    if (bus.rd_dvalid) begin
                        if (w_rd_last) begin
                            r_rd_addr   <= r_rd_addr + {25'd0, w_rd_burst, 2'b00};
                            r_rd_remain <= r_rd_remain - LEN_W'(w_rd_burst);
                            r_rd_state  <= R_IDLE;
                        end else begin
                            r_rd_beat <= r_rd_beat + 5'd1;
                        end
                    end
                end
                default: r_rd_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_state  <= W_IDLE;
            r_wr_addr   <= '0;
            r_wr_remain <= '0;
            r_wr_beat   <= '0;
        end else begin
            case (r_wr_state)
                W_IDLE: begin
                    if (w_start) begin
                        r_wr_addr   <= bus.cfg_dst_addr & 32'hFFFF_FFFC;
                        r_wr_remain <= bus.cfg_len;
                    end else if (w_wr_go) begin
                        r_wr_state <= W_REQ;
                    end
                end
                W_REQ: begin
                    if (bus.wr_ack) begin
                        r_wr_state <= W_DATA;
                        r_wr_beat  <= '0;
                    end
                end
                W_DATA: begin
                    if (bus.wr_dready) begin
                        if (w_wr_last) begin
                            r_wr_addr   <= r_wr_addr + {25'd0, w_wr_burst, 2'b00};
                            r_wr_remain <= r_wr_remain - LEN_W'(w_wr_burst);
                            r_wr_state  <= W_IDLE;
                        end else begin
                            r_wr_beat <= r_wr_beat + 5'd1;
                        end
                    end
                end
                default: r_wr_state <= W_IDLE;
            endcase
        end
    end

    assign bus.cfg_busy  = r_busy;
    assign bus.cfg_done  = r_done;

    // Command fields are gated so an idle channel presents all zeros.
    assign bus.rd_req    = (r_rd_state == R_REQ);
    assign bus.rd_addr   = bus.rd_req ? r_rd_addr : '0;
    assign bus.rd_len    = bus.rd_req ? w_rd_burst : '0;

    assign bus.wr_req    = (r_wr_state == W_REQ);
    assign bus.wr_addr   = bus.wr_req ? r_wr_addr : '0;
    assign bus.wr_len    = bus.wr_req ? w_wr_burst : '0;

    assign bus.buf_wr    = (r_rd_state == R_DATA) && bus.rd_dvalid;
    assign bus.buf_wdata = bus.buf_wr ? bus.rd_data : '0;

    assign bus.wr_dvalid = (r_wr_state == W_DATA);
    assign bus.wr_data   = bus.wr_dvalid ? bus.buf_rdata : '0;
    assign bus.wr_last   = bus.wr_dvalid && w_wr_last;
    assign bus.buf_rd    = w_wr_accept;

endmodule
